// File: rtl/snitch_cluster_cfg_regs.sv
// Runtime-programmable cluster configuration registers.
// Shadow copies of boot address, core enables and region rules are written over
// a simple request/response register bus. A commit quiesces the enabled cores,
// copies shadow to live in a single cycle, then releases the cores.
module snitch_cluster_cfg_regs #(
   parameter int unsigned          NrCores         = 8,
   parameter int unsigned          NrRegionRules   = 4,
   parameter int unsigned          AddrWidth       = 32,
   parameter logic [AddrWidth-1:0] DefaultBootAddr = AddrWidth'(32'h1e000000),
   parameter logic [AddrWidth-1:0] DefaultRuleBase = AddrWidth'(32'h1e000000),
   parameter logic [AddrWidth-1:0] DefaultRuleMask = AddrWidth'(32'h00800000),
   parameter int unsigned          TimeoutCycles   = 1024
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               req_valid_i,
   output logic                               req_ready_o,
   input  logic                               req_write_i,
   input  logic [7:0]                         req_addr_i,
   input  logic [31:0]                        req_wdata_i,
   output logic                               rsp_valid_o,
   output logic [31:0]                        rsp_rdata_o,
   output logic                               rsp_error_o,
   output logic [NrCores-1:0]                 quiesce_req_o,
   input  logic [NrCores-1:0]                 quiesce_ack_i,
   output logic [AddrWidth-1:0]               boot_addr_o,
   output logic [NrCores-1:0]                 core_en_o,
   output logic [NrRegionRules*AddrWidth-1:0] region_base_o,
   output logic [NrRegionRules*AddrWidth-1:0] region_mask_o,
   output logic [NrRegionRules-1:0]           region_en_o,
   output logic [15:0]                        cfg_gen_o
);

   localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_APPLY,
      S_RELEASE
   } state_e;

   state_e r_state, w_state_nxt;

   // Shadow registers (bus visible)
   logic [AddrWidth-1:0]     r_sh_boot;
   logic [NrCores-1:0]       r_sh_core_en;
   logic [NrRegionRules-1:0] r_sh_rule_en;
   logic [AddrWidth-1:0]     r_sh_base [NrRegionRules];
   logic [AddrWidth-1:0]     r_sh_mask [NrRegionRules];

   // Live registers (drive the outputs)
   logic [AddrWidth-1:0]     r_boot;
   logic [NrCores-1:0]       r_core_en;
   logic [NrRegionRules-1:0] r_rule_en;
   logic [AddrWidth-1:0]     r_base [NrRegionRules];
   logic [AddrWidth-1:0]     r_mask [NrRegionRules];
   logic [15:0]              r_cfg_gen;

   logic [NrCores-1:0]       r_target;
   logic [CntW-1:0]          r_cnt;
   logic                     r_timeout;
   logic                     r_rsp_valid;
   logic                     r_rsp_error;
   logic [31:0]              r_rsp_rdata;

   logic                     w_accept;
   logic                     w_busy;
   logic                     w_is_boot, w_is_core, w_is_rule_en, w_is_ctrl, w_is_status;
   logic [NrRegionRules-1:0] w_base_hit, w_mask_hit;
   logic                     w_mapped;
   logic                     w_err;
   logic                     w_wr_ok;
   logic                     w_commit;
   logic                     w_status_rd;
   logic                     w_ack_all, w_ack_none;
   logic                     w_timeout_set;
   logic [31:0]              w_rdata;

   assign req_ready_o   = (r_state != S_APPLY);
   assign w_accept      = req_valid_i & req_ready_o;
   assign w_busy        = (r_state != S_IDLE);
   assign w_ack_all     = ((quiesce_ack_i & r_target) == r_target);
   assign w_ack_none    = ((quiesce_ack_i & r_target) == '0);
   assign w_timeout_set = (r_state == S_DRAIN) & ~w_ack_all & (r_cnt == CntLast);

   // Address decode; full-address compares make misaligned addresses unmapped too
   always_comb begin
      w_is_boot    = (req_addr_i == 8'h00);
      w_is_core    = (req_addr_i == 8'h04);
      w_is_rule_en = (req_addr_i == 8'h08);
      w_is_ctrl    = (req_addr_i == 8'h0C);
      w_is_status  = (req_addr_i == 8'h10);
      w_base_hit   = '0;
      w_mask_hit   = '0;
      for (int i = 0; i < NrRegionRules; i++) begin
         w_base_hit[i] = (req_addr_i == 8'(32 + 8 * i));
         w_mask_hit[i] = (req_addr_i == 8'(36 + 8 * i));
      end
      w_mapped = w_is_boot | w_is_core | w_is_rule_en | w_is_ctrl | w_is_status |
                 (|w_base_hit) | (|w_mask_hit);
      w_err = w_accept & ((req_addr_i[1:0] != 2'b00) | ~w_mapped |
                          (req_write_i & w_is_status) |
                          (req_write_i & w_is_ctrl & req_wdata_i[0] & w_busy));
      w_wr_ok     = w_accept & req_write_i & ~w_err;
      w_commit    = w_wr_ok & w_is_ctrl & req_wdata_i[0];
      w_status_rd = w_accept & ~req_write_i & ~w_err & w_is_status;
   end

   // Read mux over shadow values and status
   always_comb begin
      w_rdata = '0;
      if (w_is_boot)    w_rdata = 32'(r_sh_boot);
      if (w_is_core)    w_rdata = 32'(r_sh_core_en);
      if (w_is_rule_en) w_rdata = 32'(r_sh_rule_en);
      if (w_is_status)  w_rdata = {r_cfg_gen, 14'd0, (r_timeout | w_timeout_set), w_busy};
      for (int i = 0; i < NrRegionRules; i++) begin
         if (w_base_hit[i]) w_rdata = 32'(r_sh_base[i]);
         if (w_mask_hit[i]) w_rdata = 32'(r_sh_mask[i]);
      end
   end

   // Commit FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Commit FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_commit) w_state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (w_ack_all)          w_state_nxt = S_APPLY;
            else if (w_timeout_set) w_state_nxt = S_RELEASE;
         end
         S_APPLY:   w_state_nxt = S_RELEASE;
         S_RELEASE: if (w_ack_none) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Drain target capture, timeout counter and sticky timeout flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_target  <= '0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_commit) r_target <= r_core_en;
         if (r_state == S_DRAIN) r_cnt <= r_cnt + 1'b1;
         else                    r_cnt <= '0;
         if (w_timeout_set)    r_timeout <= 1'b1;
         else if (w_status_rd) r_timeout <= 1'b0;
      end
   end

   // Shadow register writes from the bus
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sh_boot    <= DefaultBootAddr;
         r_sh_core_en <= '1;
         r_sh_rule_en <= NrRegionRules'(1);
         for (int i = 0; i < NrRegionRules; i++) begin
            r_sh_base[i] <= (i == 0) ? DefaultRuleBase : '0;
            r_sh_mask[i] <= (i == 0) ? DefaultRuleMask : '0;
         end
      end else if (w_wr_ok) begin
         if (w_is_boot)    r_sh_boot    <= AddrWidth'(req_wdata_i);
         if (w_is_core)    r_sh_core_en <= req_wdata_i[NrCores-1:0];
         if (w_is_rule_en) r_sh_rule_en <= req_wdata_i[NrRegionRules-1:0];
         for (int i = 0; i < NrRegionRules; i++) begin
            if (w_base_hit[i]) r_sh_base[i] <= AddrWidth'(req_wdata_i);
            if (w_mask_hit[i]) r_sh_mask[i] <= AddrWidth'(req_wdata_i);
         end
      end
   end

   // Atomic shadow-to-live copy during the single APPLY cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_boot    <= DefaultBootAddr;
         r_core_en <= '1;
         r_rule_en <= NrRegionRules'(1);
         r_cfg_gen <= '0;
         for (int i = 0; i < NrRegionRules; i++) begin
            r_base[i] <= (i == 0) ? DefaultRuleBase : '0;
            r_mask[i] <= (i == 0) ? DefaultRuleMask : '0;
         end
      end else if (r_state == S_APPLY) begin
         r_boot    <= r_sh_boot;
         r_core_en <= r_sh_core_en;
         r_rule_en <= r_sh_rule_en;
         r_cfg_gen <= r_cfg_gen + 16'd1;
         for (int i = 0; i < NrRegionRules; i++) begin
            r_base[i] <= r_sh_base[i];
            r_mask[i] <= r_sh_mask[i];
         end
      end
   end

   // Registered bus response, one cycle after acceptance
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rsp_valid <= 1'b0;
         r_rsp_error <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_accept;
         r_rsp_error <= w_err;
         r_rsp_rdata <= (w_accept & ~req_write_i & ~w_err) ? w_rdata : '0;
      end
   end

   assign rsp_valid_o   = r_rsp_valid;
   assign rsp_error_o   = r_rsp_error;
   assign rsp_rdata_o   = r_rsp_rdata;
   assign quiesce_req_o = (r_state == S_DRAIN) ? r_target : '0;
   assign boot_addr_o   = r_boot;
   assign core_en_o     = r_core_en;
   assign region_en_o   = r_rule_en;
   assign cfg_gen_o     = r_cfg_gen;

   for (genvar g = 0; g < NrRegionRules; g++) begin : g_pack
      assign region_base_o[g*AddrWidth +: AddrWidth] = r_base[g];
      assign region_mask_o[g*AddrWidth +: AddrWidth] = r_mask[g];
   end

endmodule

// File: doc/snitch_cluster_cfg_regs.md
Name: snitch_cluster_cfg_regs

Overview:
- Runtime-programmable successor to the static cluster configuration: holds boot address, core-enable mask and a parametrised number of cached/executable region rules (base/mask pairs) in shadow registers.
- Applies shadow values to live outputs atomically via a commit handshake that quiesces the enabled cores first.
- Sits between the cluster peripheral register bus and the core/PMA configuration inputs.

Parameters:
- NrCores, 8, number of cores; width of enable/quiesce vectors (1..16).
- NrRegionRules, 4, number of region rules (1..16).
- AddrWidth, 32, width of boot address and rule base/mask.
- DefaultBootAddr, 32'h1e000000, reset value of boot address.
- DefaultRuleBase, 32'h1e000000, reset base of rule 0; other rules reset to 0.
- DefaultRuleMask, 32'h00800000, reset mask of rule 0; other rules reset to 0.
- TimeoutCycles, 1024, maximum DRAIN cycles before a commit aborts.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  register request valid.
- req_ready_o  out  1  register request accepted.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  8  byte address.
- req_wdata_i  in  32  write data.
- rsp_valid_o  out  1  response valid (single-cycle pulse).
- rsp_rdata_o  out  32  read data.
- rsp_error_o  out  1  access error.
- quiesce_req_o  out  NrCores  per-core request to drain and stall.
- quiesce_ack_i  in  NrCores  per-core drained acknowledge.
- boot_addr_o  out  AddrWidth  live boot address.
- core_en_o  out  NrCores  live core enable mask.
- region_base_o  out  NrRegionRules*AddrWidth  live rule bases, rule i at [i*AddrWidth +: AddrWidth].
- region_mask_o  out  NrRegionRules*AddrWidth  live rule masks.
- region_en_o  out  NrRegionRules  live rule enables.
- cfg_gen_o  out  16  count of successful commits.

Behaviour:
- Register map (32-bit, word aligned):
  - 0x00 BOOT
  - 0x04 CORE_EN
  - 0x08 RULE_EN
  - 0x0C CTRL: write bit0 = commit; reads 0.
  - 0x10 STATUS (RO): bit0 busy, bit1 sticky timeout (cleared on read), [31:16] cfg_gen.
  - 0x20+8i RULE_BASE[i]
  - 0x24+8i RULE_MASK[i]
- Reads of BOOT, CORE_EN, RULE_EN, RULE_BASE and RULE_MASK return shadow values, zero-extended.
- Reset: shadow and live registers take their defaults; core_en = all ones; region_en = 1 for rule 0 only; cfg_gen = 0; timeout flag = 0; quiesce_req_o = 0; rsp_valid_o = 0; FSM = IDLE. Reset mid-commit aborts the commit with no partial apply.
- Bus handshake:
  - req_ready_o = 1 except in APPLY.
  - The response comes exactly 1 cycle after acceptance: rsp_valid_o for 1 cycle, rdata registered.
- Errors:
  - Conditions: addr[1:0] != 0, unmapped address, write to STATUS, or commit write while busy.
  - Result: rsp_error_o = 1, rdata = 0, no state change.
- Shadow writes are allowed in any state except APPLY. Values written during DRAIN are captured by the pending commit only if written before APPLY.
- Bits of core_en/rule_en above NrCores/NrRegionRules are ignored on write and read as 0.
- FSM:
  - IDLE: a commit write goes to DRAIN and latches target = live core_en_o (busy = 1).
  - DRAIN: quiesce_req_o = target. When (quiesce_ack_i & target) == target, go to APPLY. If the timeout counter reaches TimeoutCycles-1, set the timeout flag and go to RELEASE without applying.
  - APPLY (1 cycle): live <= shadow, cfg_gen++ (wraps 0xFFFF->0), then RELEASE.
  - RELEASE: quiesce_req_o = 0; wait until (quiesce_ack_i & target) == 0, then IDLE (busy = 0).
- If target == 0, DRAIN exits on its first cycle.
- Live outputs change only on the cycle after APPLY; they are registered and glitch-free.
- A read of STATUS in the same cycle that a timeout is set returns bit1 = 1 and leaves the flag set.

Test Plan:
- Reset -> boot_addr_o=0x1e000000, core_en_o=0xFF, region_en_o=0x1, region_base_o[0]=0x1e000000, region_mask_o[0]=0x00800000, cfg_gen_o=0.
- Write BOOT=0x1c000000, read BOOT -> rdata 0x1c000000; boot_addr_o unchanged. Commit, acks asserted 5 cycles later -> quiesce_req_o=0xFF until then; boot_addr_o=0x1c000000 one cycle after APPLY; cfg_gen_o=1.
- Commit with one core never acking -> after 1024 DRAIN cycles, live unchanged, STATUS=0x00000002 on first read, 0x00000000 on second.
- Commit while busy -> rsp_error_o=1; read addr 0x02 -> error; write 0x10 -> error; read 0x1C -> error with rdata 0.
- Write RULE_EN=0xFFFFFFFF with NrRegionRules=4 -> reads 0xF; commit -> region_en_o=0xF.
- Assert reset during DRAIN -> all outputs return to reset values next cycle, quiesce_req_o=0.
